// File: rtl/decode_instruction.sv
// decode_instruction: one-cycle registered instruction decoder; DECODE_ILLEGAL_TRAP_EN flags reserved opcodes as illegal
module decode_instruction #(
   parameter int INSTRUCTION_WIDTH = 33,
   parameter int OPCODE_W          = 5,
   parameter int REG_W             = 4,
   parameter int IMM_W             = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         instr_valid,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic [OPCODE_W-1:0]          opcode,
   output logic [REG_W-1:0]             reg_dest,
   output logic [REG_W-1:0]             reg_source_1,
   output logic [REG_W-1:0]             reg_source_2,
   output logic [IMM_W-1:0]             immediate,
   output logic                         dec_valid,
   output logic                         reg_write,
   output logic                         mem_read,
   output logic                         mem_write,
   output logic                         alu_src_imm,
   output logic [3:0]                   alu_op,
   output logic                         is_branch,
   output logic                         branch_ne,
   output logic                         is_jump,
   output logic                         halt,
   output logic                         illegal
);
   localparam int S2_LSB = IMM_W;
   localparam int S1_LSB = IMM_W + REG_W;
   localparam int RD_LSB = IMM_W + 2 * REG_W;
   logic [OPCODE_W-1:0] op;
   logic [11:0]         ctl;
   logic                illegal_d;
   assign op = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_W];
   // ctl = {reg_write, mem_read, mem_write, alu_src_imm, alu_op, is_branch, branch_ne, is_jump, halt}
   always_comb begin
      ctl = '0;
      case (op)
         5'h01: ctl = 12'b1100_0000_0000;
         5'h02: ctl = 12'b1001_0000_0000;
         5'h03: ctl = 12'b0010_0000_0000;
         5'h04: ctl = 12'b1000_0010_0000;
         5'h05: ctl = 12'b1000_0001_0000;
         5'h06: ctl = 12'b1001_0001_0000;
         5'h07: ctl = 12'b1000_0011_0000;
         5'h08: ctl = 12'b1000_0100_0000;
         5'h09: ctl = 12'b1000_0101_0000;
         5'h0A: ctl = 12'b1000_0110_0000;
         5'h0B: ctl = 12'b1000_0111_0000;
         5'h0C: ctl = 12'b0000_0000_0010;
         5'h0D: ctl = 12'b0000_0010_1000;
         5'h0E: ctl = 12'b0000_0010_1100;
         5'h0F: ctl = 12'b0000_0000_0001;
         default: ctl = '0;
      endcase
   end
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign illegal_d = op > 5'h0F;
`else
   assign illegal_d = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         {opcode, reg_dest, reg_source_1, reg_source_2, immediate} <= '0;
         {reg_write, mem_read, mem_write, alu_src_imm, alu_op, is_branch, branch_ne, is_jump, halt} <= '0;
         dec_valid <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         dec_valid <= instr_valid;
         illegal   <= instr_valid & illegal_d;
         {reg_write, mem_read, mem_write, alu_src_imm, alu_op, is_branch, branch_ne, is_jump, halt} <= instr_valid ? ctl : '0;
         if (instr_valid) begin
            opcode       <= op;
            reg_dest     <= instruction[RD_LSB +: REG_W];
            reg_source_1 <= instruction[S1_LSB +: REG_W];
            reg_source_2 <= instruction[S2_LSB +: REG_W];
            immediate    <= instruction[IMM_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_decode_instruction.sv
// tb_decode_instruction: directed vectors with hand-computed expectations for decode_instruction
module tb_decode_instruction;
   logic        clk = 1'b0;
   logic        reset, instr_valid;
   logic [32:0] instruction;
   logic [4:0]  opcode;
   logic [3:0]  reg_dest, reg_source_1, reg_source_2, alu_op;
   logic [15:0] immediate;
   logic        dec_valid, reg_write, mem_read, mem_write, alu_src_imm;
   logic        is_branch, branch_ne, is_jump, halt, illegal;
   logic [12:0] strobes;
   int          errors = 0;
   int          checks = 0;
   logic [12:0] exp_tbl [16];
   logic        trap;
   always #5 clk = ~clk;
   decode_instruction dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
      .opcode(opcode), .reg_dest(reg_dest), .reg_source_1(reg_source_1), .reg_source_2(reg_source_2),
      .immediate(immediate), .dec_valid(dec_valid), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .is_branch(is_branch),
      .branch_ne(branch_ne), .is_jump(is_jump), .halt(halt), .illegal(illegal)
   );
   // {reg_write, mem_read, mem_write, alu_src_imm, alu_op, is_branch, branch_ne, is_jump, halt, illegal}
   assign strobes = {reg_write, mem_read, mem_write, alu_src_imm, alu_op, is_branch, branch_ne, is_jump, halt, illegal};
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic r, input logic v, input logic [32:0] w);
      reset = r;
      instr_valid = v;
      instruction = w;
      @(posedge clk);
      #1;
   endtask
   initial begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      trap = 1'b1;
`else
      trap = 1'b0;
`endif
      exp_tbl[0]  = 13'b0000_0000_00000;
      exp_tbl[1]  = 13'b1100_0000_00000;
      exp_tbl[2]  = 13'b1001_0000_00000;
      exp_tbl[3]  = 13'b0010_0000_00000;
      exp_tbl[4]  = 13'b1000_0010_00000;
      exp_tbl[5]  = 13'b1000_0001_00000;
      exp_tbl[6]  = 13'b1001_0001_00000;
      exp_tbl[7]  = 13'b1000_0011_00000;
      exp_tbl[8]  = 13'b1000_0100_00000;
      exp_tbl[9]  = 13'b1000_0101_00000;
      exp_tbl[10] = 13'b1000_0110_00000;
      exp_tbl[11] = 13'b1000_0111_00000;
      exp_tbl[12] = 13'b0000_0000_00100;
      exp_tbl[13] = 13'b0000_0010_10000;
      exp_tbl[14] = 13'b0000_0010_11000;
      exp_tbl[15] = 13'b0000_0000_00010;
      step(1'b1, 1'b1, 33'h052210000);
      check("rst_strobes", 32'(strobes), 0);
      check("rst_valid", 32'(dec_valid), 0);
      check("rst_fields", {opcode, reg_dest, reg_source_1, reg_source_2, immediate}, 0);
      step(1'b0, 1'b1, 33'h011000010);
      check("ld_fields", {opcode, reg_dest, reg_source_1, reg_source_2, immediate}, 32'h0_1_0_0_0010 | (32'h01 << 28));
      check("ld_strobes", 32'(strobes), 32'(13'b1100_0000_00000));
      check("ld_valid", 32'(dec_valid), 1);
      step(1'b0, 1'b1, 33'h052210000);
      check("add_op", 32'(opcode), 5);
      check("add_regs", {20'h0, reg_dest, reg_source_1, reg_source_2}, 32'h221);
      check("add_strobes", 32'(strobes), 32'(13'b1000_0001_00000));
      step(1'b0, 1'b1, 33'h030100030);
      check("st_op", 32'(opcode), 3);
      check("st_s1_imm", {12'h0, reg_source_1, immediate}, 32'h10030);
      check("st_strobes", 32'(strobes), 32'(13'b0010_0000_00000));
      step(1'b0, 1'b1, 33'h02300000A);
      check("li_dest_imm", {12'h0, reg_dest, immediate}, 32'h3000A);
      check("li_strobes", 32'(strobes), 32'(13'b1001_0000_00000));
      step(1'b0, 1'b1, 33'h0E130FFFD);
      check("bne_regs_imm", {8'h0, reg_dest, reg_source_1, immediate}, 32'h13FFFD);
      check("bne_strobes", 32'(strobes), 32'(13'b0000_0010_11000));
      step(1'b0, 1'b1, 33'h061000001);
      check("addi_dest_imm", {12'h0, reg_dest, immediate}, 32'h10001);
      check("addi_strobes", 32'(strobes), 32'(13'b1001_0001_00000));
      step(1'b0, 1'b0, 33'h1FFFFFFFF);
      check("idle_valid", 32'(dec_valid), 0);
      check("idle_strobes", 32'(strobes), 0);
      check("idle_hold", {opcode, reg_dest, reg_source_1, reg_source_2, immediate}, {5'h06, 4'h1, 4'h0, 4'h0, 16'h0001});
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, {5'(i), 4'(15 - i), 4'(i), 4'(i ^ 5), 16'(i * 257)});
         check($sformatf("map%0d_strobes", i), 32'(strobes), 32'(exp_tbl[i]));
         check($sformatf("map%0d_valid", i), 32'(dec_valid), 1);
         check($sformatf("map%0d_fields", i), {opcode, reg_dest, reg_source_1, reg_source_2, immediate},
               {5'(i), 4'(15 - i), 4'(i), 4'(i ^ 5), 16'(i * 257)});
      end
      step(1'b0, 1'b1, 33'h1F0000000);
      check("rsv_valid", 32'(dec_valid), 1);
      check("rsv_op", 32'(opcode), 32'h1F);
      check("rsv_strobes", 32'(strobes), {31'h0, trap});
      step(1'b0, 1'b1, 33'h100000000);
      check("rsv10_strobes", 32'(strobes), {31'h0, trap});
      step(1'b0, 1'b1, 33'h0F0000000);
      check("halt_after_rsv", 32'(strobes), 32'(13'b0000_0000_00010));
      step(1'b1, 1'b1, 33'h0F0000000);
      check("rst2_all", {16'h0, 2'b0, dec_valid, strobes}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
